// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared constants for the S/PDIF transmitter
package spdif_pkg;

    localparam int HC_PER_SUBFRAME = 64;

    // Preamble half-cell patterns, sent MSB first, as seen after a line level of 0.
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam logic [4:0] SLOT_AUX = 5'd4;
    localparam logic [4:0] SLOT_V   = 5'd28;
    localparam logic [4:0] SLOT_U   = 5'd29;
    localparam logic [4:0] SLOT_C   = 5'd30;
    localparam logic [4:0] SLOT_P   = 5'd31;

    typedef enum logic {
        SUB_L = 1'b0,
        SUB_R = 1'b1
    } sub_t;

endpackage

// File: rtl/spdif_bmc_cell.sv
// rtl/spdif_bmc_cell.sv - next biphase-mark line level for one half-cell
module spdif_bmc_cell
    import spdif_pkg::*;
(
    input  logic [5:0] hc,
    input  logic       slot_bit,
    input  logic [7:0] pattern,
    input  logic       is_preamble,
    input  logic       level,
    output logic       next_level
);

    logic [8:0] pat_shift;
    logic       toggle;

    // Preambles toggle wherever the pattern changes from the previous half-cell,
    // which makes the inverted form fall out of the current level for free.
    always_comb begin
        pat_shift = {1'b0, pattern} << hc[2:0];
        if (is_preamble) begin
            toggle = pat_shift[8] ^ pat_shift[7];
        end else begin
            toggle = ~hc[0] | slot_bit;
        end
        next_level = level ^ toggle;
    end

endmodule

// File: rtl/spdif_tx.sv
// rtl/spdif_tx.sv - S/PDIF transmitter: PCM pairs to biphase-mark line
module spdif_tx
    import spdif_pkg::*;
#(
    parameter int DATA_W           = 24,
    parameter int FRAMES_PER_BLOCK = 192,
    parameter int CLK_DIV          = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data_l,
    input  logic [DATA_W-1:0] s_data_r,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              valid_flag,
    input  logic [31:0]       cs_i,
    output logic              spdif_o,
    output logic              block_start,
    output logic              underrun
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRAME_W = (FRAMES_PER_BLOCK > 1) ? $clog2(FRAMES_PER_BLOCK) : 1;
    localparam int PAD_W   = 24 - DATA_W;

    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         hc;
    sub_t               sub;
    logic [FRAME_W-1:0] frame;
    logic               tick;
    logic               frame_start;

    logic               hold_full;
    logic [DATA_W-1:0]  hold_l;
    logic [DATA_W-1:0]  hold_r;
    logic               hold_v;

    logic [DATA_W-1:0]  sh_l;
    logic [DATA_W-1:0]  sh_r;
    logic               sh_v;
    logic               c_bit;
    logic               c_next;
    logic               parity;

    logic [4:0]         slot;
    logic [23:0]        audio;
    logic               slot_bit;
    logic [7:0]         pattern;
    logic               is_preamble;
    logic               next_level;

    assign tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign frame_start = tick && (sub == SUB_L) && (hc == 6'd0);
    assign s_ready     = ~hold_full;
    assign slot        = hc[5:1];
    assign is_preamble = (hc[5:3] == 3'd0);

    // Samples are MSB-aligned to slot 27; narrower words leave the low slots at 0.
    assign audio   = 24'(sub == SUB_L ? sh_l : sh_r) << PAD_W;
    assign pattern = (sub == SUB_R) ? PRE_W : ((frame == '0) ? PRE_B : PRE_M);
    assign c_next  = (32'(frame) < 32'd32) ? cs_i[5'(frame)] : 1'b0;

    always_comb begin
        slot_bit = 1'b0;
        if (slot >= SLOT_AUX && slot < SLOT_V) begin
            slot_bit = audio[slot - SLOT_AUX];
        end else if (slot == SLOT_V) begin
            slot_bit = sh_v;
        end else if (slot == SLOT_C) begin
            slot_bit = c_bit;
        end else if (slot == SLOT_P) begin
            slot_bit = parity;
        end
    end

    spdif_bmc_cell u_cell (
        .hc          (hc),
        .slot_bit    (slot_bit),
        .pattern     (pattern),
        .is_preamble (is_preamble),
        .level       (spdif_o),
        .next_level  (next_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            hc          <= '0;
            sub         <= SUB_L;
            frame       <= '0;
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            hold_v      <= 1'b0;
            sh_l        <= '0;
            sh_r        <= '0;
            sh_v        <= 1'b0;
            c_bit       <= 1'b0;
            parity      <= 1'b0;
            spdif_o     <= 1'b0;
            block_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            block_start <= 1'b0;
            underrun    <= 1'b0;
            div_cnt     <= tick ? '0 : div_cnt + 1'b1;

            // s_ready is low on the move edge, so load and move never collide.
            if (frame_start && hold_full) begin
                hold_full <= 1'b0;
            end else if (s_valid && !hold_full) begin
                hold_l    <= s_data_l;
                hold_r    <= s_data_r;
                hold_v    <= valid_flag;
                hold_full <= 1'b1;
            end

            if (tick) begin
                spdif_o <= next_level;
                hc      <= hc + 6'd1;
                if (hc == 6'(HC_PER_SUBFRAME - 1)) begin
                    sub <= sub_t'(~sub);
                    if (sub == SUB_R) begin
                        frame <= (frame == FRAME_W'(FRAMES_PER_BLOCK - 1)) ? '0 : frame + 1'b1;
                    end
                end

                // Parity covers slots 4..30 and is consumed during slot 31.
                if (is_preamble) begin
                    parity <= 1'b0;
                end else if (hc[0] && slot != SLOT_P) begin
                    parity <= parity ^ slot_bit;
                end

                if (frame_start) begin
                    block_start <= (frame == '0);
                    c_bit       <= c_next;
                    if (hold_full) begin
                        sh_l <= hold_l;
                        sh_r <= hold_r;
                        sh_v <= hold_v;
                    end else begin
                        sh_l     <= '0;
                        sh_r     <= '0;
                        sh_v     <= 1'b1;
                        underrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_tx.sv
// tb/tb_spdif_tx.sv - directed self-checking bench for spdif_tx
module tb_spdif_tx;

    localparam int DATA_W = 16;
    localparam int FPB    = 4;
    localparam int CDIV   = 2;
    localparam int HCF    = 128;
    localparam logic [7:0] B_PAT = 8'b1110_1000;
    localparam logic [7:0] M_PAT = 8'b1110_0010;
    localparam logic [7:0] W_PAT = 8'b1110_0100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] s_data_l;
    logic [DATA_W-1:0] s_data_r;
    logic              s_valid;
    logic              s_ready;
    logic              valid_flag;
    logic [31:0]       cs_i;
    logic              spdif_o;
    logic              block_start;
    logic              underrun;

    spdif_tx #(
        .DATA_W           (DATA_W),
        .FRAMES_PER_BLOCK (FPB),
        .CLK_DIV          (CDIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data_l    (s_data_l),
        .s_data_r    (s_data_r),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .valid_flag  (valid_flag),
        .cs_i        (cs_i),
        .spdif_o     (spdif_o),
        .block_start (block_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    logic lv [0:2047];
    int hcnt, ph, clk_i, hold_errs;
    int bs_q[$];
    int ur_q[$];
    logic [DATA_W-1:0] q_l[$];
    logic [DATA_W-1:0] q_r[$];
    logic              q_v[$];
    logic              feeding;
    logic [31:0]       cs_bits;
    logic [DATA_W-1:0] el [0:10];
    logic [DATA_W-1:0] er [0:10];
    logic              ev [0:10];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input logic v);
        q_l.push_back(l);
        q_r.push_back(r);
        q_v.push_back(v);
    endtask

    // One clk: sample the line once per half-cell, log pulses, drive the handshake.
    task automatic step();
        if (ph == 0) begin
            if (hcnt < 2048) lv[hcnt] = spdif_o;
        end else if (hcnt < 2048 && spdif_o !== lv[hcnt]) begin
            hold_errs++;
        end
        if (block_start === 1'b1) bs_q.push_back(clk_i);
        if (underrun === 1'b1) ur_q.push_back(clk_i);
        ph++;
        if (ph == CDIV) begin
            ph = 0;
            hcnt++;
        end
        if (feeding) begin
            void'(q_l.pop_front());
            void'(q_r.pop_front());
            void'(q_v.pop_front());
            feeding = 1'b0;
            s_valid = 1'b0;
        end
        if (s_ready === 1'b1 && q_l.size() > 0) begin
            s_data_l   = q_l[0];
            s_data_r   = q_r[0];
            valid_flag = q_v[0];
            s_valid    = 1'b1;
            feeding    = 1'b1;
        end
        clk_i++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic sync_block();
        int n;
        n = 0;
        while (block_start !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("sync_block_start", 64'(block_start), 64'(1'b1));
        hcnt = 0;
        ph = 0;
        clk_i = 0;
        hold_errs = 0;
        bs_q.delete();
        ur_q.delete();
    endtask

    function automatic logic [7:0] pre_of(input int b);
        logic       p;
        logic [7:0] r;
        p = 1'b0;
        if (b > 0) p = lv[b-1];
        for (int k = 0; k < 8; k++) r[7-k] = lv[b+k] ^ p;
        return r;
    endfunction

    function automatic logic [31:0] slots_of(input int b);
        logic [31:0] r;
        r = '0;
        for (int s = 4; s < 32; s++) r[s] = lv[b+2*s] ^ lv[b+2*s+1];
        return r;
    endfunction

    function automatic int bmc_errs(input int b);
        int e;
        e = 0;
        for (int s = 4; s < 32; s++) if (lv[b+2*s] === lv[b+2*s-1]) e++;
        return e;
    endfunction

    function automatic logic [31:0] exp_word(input logic [DATA_W-1:0] d, input logic v, input logic c);
        logic [31:0] w;
        w = '0;
        w[27:4] = {d, 8'h00};
        w[28] = v;
        w[30] = c;
        w[31] = ^w[30:4];
        return w;
    endfunction

    task automatic chk_frame(input int f, input int fn, input logic [DATA_W-1:0] l,
                             input logic [DATA_W-1:0] r, input logic v);
        int   b;
        logic c;
        b = f * HCF;
        c = cs_bits[fn];
        chk($sformatf("preamble_f%0d", f), 64'({pre_of(b), pre_of(b + 64)}),
            64'({(fn == 0) ? B_PAT : M_PAT, W_PAT}));
        chk($sformatf("slots_f%0d", f), {slots_of(b), slots_of(b + 64)},
            {exp_word(l, v, c), exp_word(r, v, c)});
    endtask

    initial begin
        int n;
        int errs;
        logic [7:0] raw;

        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data_l = '0;
        s_data_r = '0;
        valid_flag = 1'b0;
        cs_bits = 32'h0000_0005;
        cs_i = cs_bits;
        feeding = 1'b0;
        hcnt = 0;
        ph = 0;
        clk_i = 0;
        hold_errs = 0;

        repeat (4) @(negedge clk);
        chk("rst_spdif_o", 64'(spdif_o), 64'(1'b0));
        chk("rst_s_ready", 64'(s_ready), 64'(1'b1));
        chk("rst_block_start", 64'(block_start), 64'(1'b0));
        chk("rst_underrun", 64'(underrun), 64'(1'b0));
        rst_n = 1'b1;

        // Frame 0 with nothing offered: underrun frame opening the block.
        sync_block();
        chk("underrun_with_block_start", 64'(underrun), 64'(1'b1));
        run(HCF * CDIV);
        for (int k = 0; k < 8; k++) raw[7-k] = lv[k];
        chk("raw_b_preamble", 64'(raw), 64'(B_PAT));
        chk_frame(0, 0, '0, '0, 1'b1);

        el[1] = '0;          er[1] = '0;          ev[1] = 1'b1;
        el[2] = 16'h0001;    er[2] = 16'h8000;    ev[2] = 1'b0;
        el[3] = 16'hABCD;    er[3] = 16'h1234;    ev[3] = 1'b1;
        for (int k = 4; k <= 10; k++) begin
            el[k] = 16'(k * 16'h0101);
            er[k] = 16'(16'hF000 + k);
            ev[k] = k[0];
        end
        for (int k = 2; k <= 10; k++) push(el[k], er[k], ev[k]);

        run(10 * HCF * CDIV);
        for (int f = 1; f <= 10; f++) chk_frame(f, f % FPB, el[f], er[f], ev[f]);
        chk("underrun_count", 64'(ur_q.size()), 64'(2));
        chk("underrun_spacing", 64'(ur_q[1] - ur_q[0]), 64'(HCF * CDIV));
        chk("block_start_count", 64'(bs_q.size()), 64'(3));
        chk("block_start_period_a", 64'(bs_q[1] - bs_q[0]), 64'(FPB * HCF * CDIV));
        chk("block_start_period_b", 64'(bs_q[2] - bs_q[1]), 64'(FPB * HCF * CDIV));
        chk("half_cell_hold", 64'(hold_errs), 64'(0));
        errs = 0;
        for (int h = 0; h < 22; h++) errs += bmc_errs(h * 64);
        chk("bmc_cell_edges", 64'(errs), 64'(0));

        // Leave a pair pending, then reset in the middle of an R subframe.
        push(16'h7777, 16'h7777, 1'b0);
        run((64 + 20) * CDIV);
        n = 0;
        while (spdif_o !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("line_high_before_reset", 64'(spdif_o), 64'(1'b1));
        chk("pair_pending_before_reset", 64'(s_ready), 64'(1'b0));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_spdif_o", 64'(spdif_o), 64'(1'b0));
        chk("midrst_s_ready", 64'(s_ready), 64'(1'b1));
        chk("midrst_block_start", 64'(block_start), 64'(1'b0));
        chk("midrst_underrun", 64'(underrun), 64'(1'b0));
        rst_n = 1'b1;

        sync_block();
        chk("midrst_pair_discarded", 64'(underrun), 64'(1'b1));
        run(HCF * CDIV);
        for (int k = 0; k < 8; k++) raw[7-k] = lv[k];
        chk("midrst_raw_b_preamble", 64'(raw), 64'(B_PAT));
        chk_frame(0, 0, '0, '0, 1'b1);
        chk("midrst_underrun_count", 64'(ur_q.size()), 64'(1));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

endmodule

// File: doc/spdif_tx.md
Name: spdif_tx

Overview:
- Parametrised S/PDIF (IEC 60958) transmitter: serialises stereo PCM pairs into a biphase-mark stream with B/M/W preambles, V/U/C/P bits and a configurable block length.
- Sits at the output side of dmix as the counterpart of the receiver in dmix_top.
- Also serves as a synthesizable stimulus source for receiver benches, replacing hand-sequenced tasks.

Parameters:
- DATA_W, 24: audio sample width, 16..24.
- FRAMES_PER_BLOCK, 192: frames between B preambles, 2..192.
- CLK_DIV, 1: clk cycles per half-cell (UI). Must be at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- s_data_l  in  DATA_W  left sample
- s_data_r  in  DATA_W  right sample
- s_valid  in  1  sample pair valid
- s_ready  out  1  holding register empty
- valid_flag  in  1  V bit value for supplied samples
- cs_i  in  32  channel-status bits 0..31 of the block
- spdif_o  out  1  biphase-mark line output
- block_start  out  1  one-clk pulse when a B preamble begins
- underrun  out  1  one-clk pulse when a frame starts with no pair available

Behaviour:
- Reset (rst_n=0 at a clk edge): spdif_o=0, s_ready=1, block_start=0, underrun=0. Holding register is emptied; div, half-cell, subframe and frame counters all go to 0. The first subframe after reset is a B subframe. Reset mid-subframe aborts it immediately.
- Tick: the div counter counts 0..CLK_DIV-1. A tick occurs at wrap. spdif_o is registered and changes only on ticks.
- Subframe layout: 64 half-cells (hc 0..63) = 32 slots.
  - Slots 0-3: preamble.
  - Slots 4-27: audio, LSB first. The sample is MSB-aligned in slot 27; slots below 28-DATA_W are sent as 0.
  - Slot 28: V. Slot 29: U (always 0). Slot 30: C. Slot 31: P.
  - P makes slots 4..31 even parity.
- Preamble half-cells, when the previous line level is 0:
  - B = 11101000
  - M = 11100010
  - W = 11100100
  - When the previous level is 1, the pattern is bitwise inverted.
- Preamble selection: L subframe uses B if frame==0, else M. R subframe uses W.
- Data slots: hc even toggles the line. hc odd toggles only if the bit is 1.
- Frame counter: increments after each R subframe and wraps to 0 at FRAMES_PER_BLOCK.
  - C bit for frame n is cs_i[n] for n<32, else 0. The same value is used in both subframes.
  - cs_i is sampled at L hc 0.
- Handshake: a transfer occurs when s_valid && s_ready.
  - On transfer, the holding register is loaded and s_ready drops on the next clk.
  - On the tick starting L hc 0, the holding register moves to the shift register and s_ready rises on the next clk.
  - A transfer on the same clk as that move is not permitted (s_ready is 0 then), so there is no collision.
- Latency: a pair accepted while a frame is in flight is sent in the next frame. The L preamble begins at most one frame plus one tick after acceptance.
- Underrun: if the holding register is empty at L hc 0:
  - The frame is sent with audio = 0 and V = 1 in both subframes.
  - underrun pulses for 1 clk.
  - Counters advance normally.
- block_start: pulses for 1 clk on the tick starting L hc 0 of frame 0.
- V for supplied data is valid_flag, captured together with the samples.

Decomposition:
- Package spdif_pkg holds:
  - PRE_B/PRE_M/PRE_W 8-bit constants (level-0 form)
  - slot indices SLOT_AUX/SLOT_V/SLOT_U/SLOT_C/SLOT_P
  - HC_PER_SUBFRAME=64
- One sub-module, spdif_bmc_cell: combinational next-level generator from (hc, slot bit, preamble pattern, is_preamble, current level). The top keeps counters, handshake, parity accumulator and output register.

Test Plan:
- Reset, then no s_valid for one frame: spdif_o=0 during reset; first L hc 0..7 = 11101000; underrun pulses once; decoded V=1, audio 0x000000; block_start pulses at the same tick.
- Pair L=0x000001, R=0x800000, valid_flag=0, CLK_DIV=2: receiver model decodes L slot4=1, R slot27=1, V=0. P gives even parity over slots 4-31. Each half-cell lasts exactly 2 clk.
- FRAMES_PER_BLOCK=4, continuous valid pairs with counting data: preamble sequence B W M W M W M W B W. block_start period is 4×128×CLK_DIV clk. No underrun.
- cs_i=32'h0000_0005: C=1 in frames 0 and 2, C=0 in frames 1, 3 and ≥32.
- DATA_W=16, L=16'hABCD: slots 4-11 = 0, slots 12-27 carry 0xABCD LSB first.
- Assert rst_n=0 mid-R subframe for 1 clk: spdif_o=0 next clk, s_ready=1, the next transmitted preamble is B, and the pending pair is discarded.
